// File: rtl/stream_demux_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer and its channel FIFOs.
package stream_demux_pkg;

    localparam int NUM_CH     = 4;  // output channels
    localparam int SEL_W      = 2;  // width of the channel select
    localparam int CNT_W      = 3;  // per-channel occupancy counter width
    localparam int DATA_W_DEF = 8;  // default payload width
    localparam int DEPTH_DEF  = 2;  // default entries per channel (2 or 4)

endpackage : stream_demux_pkg

// File: rtl/chan_fifo.sv
// Single-clock FIFO used as one output channel buffer of the demux.
// Power-of-two depth (2 or 4): pointers wrap naturally modulo DEPTH.
module chan_fifo
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    // Guards keep the counter saturated even if a caller misbehaves.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next-state for pointers and occupancy.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;  // idle, or push and pop cancel
        endcase
    end

    // Pointer and occupancy registers; reset empties the channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage write at the tail.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; an empty channel never exposes it as valid.
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = cnt_q;

endmodule : chan_fifo

// File: rtl/stream_demux_1to4.sv
// 1-to-4 stream demultiplexer: each input word is routed by in_sel into one
// of four buffered output channels with independent valid/ready handshakes.
module stream_demux_1to4
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic [DATA_W-1:0]        in_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH*CNT_W-1:0]  out_count
);

    logic [NUM_CH-1:0] push_en;
    logic [NUM_CH-1:0] pop_en;
    logic [NUM_CH-1:0] full_w;
    logic [NUM_CH-1:0] empty_w;

    // Ready depends only on the selected channel's registered fullness, so a
    // full channel refuses a push even in a cycle where it is also popped.
    assign in_ready  = ~full_w[in_sel] & rst_n;
    assign out_valid = ~empty_w;
    assign pop_en    = out_valid & out_ready;

    // Decode the accepted word onto exactly one channel's push enable.
    always_comb begin
        push_en = '0;
        if (in_valid && in_ready) push_en[in_sel] = 1'b1;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push_en[k]),
            .pop   (pop_en[k]),
            .wdata (in_data),
            .rdata (out_data[k*DATA_W +: DATA_W]),
            .count (out_count[k*CNT_W +: CNT_W]),
            .full  (full_w[k]),
            .empty (empty_w[k])
        );
    end

endmodule : stream_demux_1to4
